// File: rtl/spine_switch.sv
// Spine-side switch for one leaf group: four input FIFOs, per-output
// round-robin arbitration, and registered egress to the four leaves.
module spine_switch #(
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] GROUP_ID   = 4'b0111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arb_enable,
    input  logic [4*DWIDTH-1:0] leaf_in_data,
    input  logic [3:0]          leaf_in_valid,
    input  logic [23:0]         leaf_in_dest_addr,
    output logic [4*DWIDTH-1:0] leaf_out_data,
    output logic [3:0]          leaf_out_valid,
    output logic [23:0]         leaf_out_dest_addr,
    output logic [3:0]          fifo_full,
    output logic [3:0]          fifo_empty,
    output logic [15:0]         drop_count,
    output logic                busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // FIFO entry layout: {dest[5:0], data[DWIDTH-1:0]}
    localparam int EW = DWIDTH + 6;

    logic [3:0][EW-1:0] head;     // head entry of each input FIFO
    logic [3:0][3:0]    gnt;      // gnt[output][input]
    logic [3:0]         pop;
    logic [3:0]         push;
    logic [3:0]         drop;
    logic [2:0]         drop_num;
    logic [15:0]        drop_count_q, drop_count_d;

    // Input side: one FIFO per leaf with group filtering and overflow drop
    for (genvar gi = 0; gi < 4; gi++) begin : g_in
        logic [AW:0]   wr_ptr_q, rd_ptr_q;
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [5:0]    in_dest;

        assign in_dest        = leaf_in_dest_addr[gi*6 +: 6];
        assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
        assign fifo_full[gi]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign head[gi]       = mem[rd_ptr_q[AW-1:0]];
        // A full FIFO that is popped this cycle still has room for the push
        assign push[gi] = leaf_in_valid[gi] && (in_dest[5:2] == GROUP_ID) &&
                          (!fifo_full[gi] || pop[gi]);
        assign drop[gi] = leaf_in_valid[gi] && !push[gi];

        // Read/write pointers advance on pop/push
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end

        // Storage is not reset; the pointers define what is valid
        always_ff @(posedge clk) begin
            if (push[gi]) mem[wr_ptr_q[AW-1:0]] <= {in_dest, leaf_in_data[gi*DWIDTH +: DWIDTH]};
        end
    end

    // Output side: round-robin grant among heads addressing this leaf
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        logic [1:0]        rr_ptr_q;
        logic [3:0]        gnt_c;
        logic [1:0]        sel;
        logic [1:0]        idx;
        logic              found;
        logic              valid_q;
        logic [DWIDTH-1:0] data_q;
        logic [5:0]        dest_q;

        // Scan inputs starting at the round-robin pointer; first requester wins
        always_comb begin
            gnt_c = '0;
            sel   = '0;
            idx   = '0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr_q + k[1:0];
                if (!found && arb_enable && !fifo_empty[idx] &&
                    head[idx][DWIDTH+1:DWIDTH] == 2'(gi)) begin
                    gnt_c[idx] = 1'b1;
                    sel        = idx;
                    found      = 1'b1;
                end
            end
        end

        assign gnt[gi] = gnt_c;

        // Register the granted flit and advance the pointer past the winner
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rr_ptr_q <= '0;
                valid_q  <= 1'b0;
                data_q   <= '0;
                dest_q   <= '0;
            end else begin
                valid_q <= found;
                if (found) begin
                    rr_ptr_q <= sel + 2'd1;
                    data_q   <= head[sel][DWIDTH-1:0];
                    dest_q   <= head[sel][EW-1:DWIDTH];
                end
            end
        end

        assign leaf_out_valid[gi]                 = valid_q;
        assign leaf_out_data[gi*DWIDTH +: DWIDTH] = data_q;
        assign leaf_out_dest_addr[gi*6 +: 6]      = dest_q;
    end

    // An input is popped when any output granted it (at most one can)
    always_comb begin
        pop = '0;
        for (int j = 0; j < 4; j++) pop = pop | gnt[j];
    end

    // Count flits discarded this cycle and saturate the running total
    always_comb begin
        logic [16:0] sum;
        drop_num = '0;
        for (int i = 0; i < 4; i++) drop_num = drop_num + {2'b00, drop[i]};
        sum          = {1'b0, drop_count_q} + {14'd0, drop_num};
        drop_count_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Drop counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_count_q <= '0;
        else        drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
    assign busy       = (~&fifo_empty) | (|leaf_out_valid);

endmodule

// File: tb/tb_spine_switch.sv
// Randomized and directed bench for spine_switch against a queue-level model.
module tb_spine_switch;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_enable;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [23:0] in_dest;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [23:0] out_dest;
    logic [3:0]  fifo_full, fifo_empty;
    logic [15:0] drop_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: per-input queues of {dest, data}
    logic [21:0] mq [4][DEPTH];
    int          mcnt [4];
    int          mrr [4];
    int          mdrop;
    logic [3:0]  exp_v;
    logic [15:0] exp_dat [4];
    logic [5:0]  exp_dst [4];

    spine_switch dut (
        .clk                (clk),
        .reset              (reset),
        .arb_enable         (arb_enable),
        .leaf_in_data       (in_data),
        .leaf_in_valid      (in_valid),
        .leaf_in_dest_addr  (in_dest),
        .leaf_out_data      (out_data),
        .leaf_out_valid     (out_valid),
        .leaf_out_dest_addr (out_dest),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .drop_count         (drop_count),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0;
            mrr[i]  = 0;
        end
        mdrop = 0;
        exp_v = '0;
    endtask

    // One clock of the switching rules: grant from current heads, pop, then push
    task automatic model_step(input logic en, input logic [3:0] v,
                              input logic [23:0] d, input logic [63:0] dat);
        logic [3:0] popi;
        logic [5:0] dd;
        popi  = '0;
        exp_v = '0;
        for (int j = 0; j < 4; j++) begin
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (mrr[j] + k) % 4;
                    if (!exp_v[j] && mcnt[i] > 0 && mq[i][0][17:16] == 2'(j)) begin
                        exp_v[j]   = 1'b1;
                        exp_dat[j] = mq[i][0][15:0];
                        exp_dst[j] = mq[i][0][21:16];
                        mrr[j]     = (i + 1) % 4;
                        popi[i]    = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (popi[i]) begin
                for (int s = 0; s < DEPTH - 1; s++) mq[i][s] = mq[i][s+1];
                mcnt[i]--;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                dd = d[i*6 +: 6];
                if (dd[5:2] != 4'b0111 || mcnt[i] == DEPTH) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    mq[i][mcnt[i]] = {dd, dat[i*16 +: 16]};
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] ef, ee;
        logic       eb;
        eb = |exp_v;
        for (int i = 0; i < 4; i++) begin
            ef[i] = (mcnt[i] == DEPTH);
            ee[i] = (mcnt[i] == 0);
            if (mcnt[i] > 0) eb = 1'b1;
        end
        chk_eq("out_valid", 32'(out_valid), 32'(exp_v));
        for (int j = 0; j < 4; j++) begin
            if (exp_v[j]) begin
                chk_eq($sformatf("out_data%0d", j), 32'(out_data[j*16 +: 16]), 32'(exp_dat[j]));
                chk_eq($sformatf("out_dest%0d", j), 32'(out_dest[j*6 +: 6]), 32'(exp_dst[j]));
            end
        end
        chk_eq("fifo_full", 32'(fifo_full), 32'(ef));
        chk_eq("fifo_empty", 32'(fifo_empty), 32'(ee));
        chk_eq("drop_count", 32'(drop_count), 32'(mdrop));
        chk_eq("busy", 32'(busy), 32'(eb));
    endtask

    // Drive one cycle of stimulus, advance model and DUT, then compare
    task automatic step(input logic en, input logic [3:0] v,
                        input logic [23:0] d, input logic [63:0] dat);
        arb_enable = en;
        in_valid   = v;
        in_dest    = d;
        in_data    = dat;
        model_step(en, v, d, dat);
        @(posedge clk);
        #1;
        in_valid = '0;
        cyc++;
        check_outputs();
        $display("cyc %0d en=%0b in_v=%b out_v=%b full=%b empty=%b drop=%0d",
                 cyc, en, v, out_valid, fifo_full, fifo_empty, drop_count);
    endtask

    task automatic idle(input logic en, input int n);
        for (int k = 0; k < n; k++) step(en, 4'b0000, 24'd0, 64'd0);
    endtask

    initial begin
        logic [23:0] d;
        logic [63:0] dat;
        logic [3:0]  v;
        logic        en;

        reset = 1'b0;
        arb_enable = 1'b1;
        in_valid = '0;
        in_dest = '0;
        in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_eq("rst_valid", 32'(out_valid), 32'h0);
        chk_eq("rst_empty", 32'(fifo_empty), 32'hF);
        chk_eq("rst_full", 32'(fifo_full), 32'h0);
        chk_eq("rst_drop", 32'(drop_count), 32'h0);
        chk_eq("rst_busy", 32'(busy), 32'h0);

        // Single flit leaf 0 -> leaf 2, one-cycle latency
        step(1'b1, 4'b0001, {18'd0, 6'b011110}, {48'd0, 16'hA5A5});
        chk_eq("single_early", 32'(out_valid), 32'h0);
        idle(1'b1, 1);
        chk_eq("single_v", 32'(out_valid), 32'h4);
        chk_eq("single_data", 32'(out_data[47:32]), 32'hA5A5);
        chk_eq("single_dest", 32'(out_dest[17:12]), 32'h1E);
        idle(1'b1, 1);

        // Contention: leaves 0,1,3 all to leaf 1
        step(1'b1, 4'b1011, {4{6'b011101}}, {16'h1003, 16'h1002, 16'h1001, 16'h1000});
        idle(1'b1, 1);
        chk_eq("rr_first", 32'(out_data[31:16]), 32'h1000);
        idle(1'b1, 1);
        chk_eq("rr_second", 32'(out_data[31:16]), 32'h1001);
        idle(1'b1, 1);
        chk_eq("rr_third", 32'(out_data[31:16]), 32'h1003);
        idle(1'b1, 1);

        // Wrong group from leaf 2
        step(1'b1, 4'b0100, {6'd0, 6'b010000, 12'd0}, 64'd0);
        chk_eq("wrong_grp_drop", 32'(drop_count), 32'd1);
        idle(1'b1, 1);

        // Overflow with arbitration disabled, then drain in order
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 4'b1000, {6'b011100, 18'd0}, {16'(16'h3000 + n), 48'd0});
            if (n == 7) chk_eq("ovf_full", 32'(fifo_full[3]), 32'd1);
        end
        chk_eq("ovf_drop", 32'(drop_count), 32'd3);
        idle(1'b1, 9);

        // Parallel permutation: all four outputs in the same cycle
        d   = {6'b011100, 6'b011111, 6'b011110, 6'b011101};
        dat = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
        step(1'b1, 4'b1111, d, dat);
        step(1'b1, 4'b1111, d, dat ^ 64'hFFFF_FFFF_FFFF_FFFF);
        chk_eq("perm_all", 32'(out_valid), 32'hF);

        // Async reset between edges while flits are queued and outputs valid
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_eq("arst_valid", 32'(out_valid), 32'h0);
        chk_eq("arst_data", out_data[31:0], 32'h0);
        chk_eq("arst_empty", 32'(fifo_empty), 32'hF);
        chk_eq("arst_drop", 32'(drop_count), 32'h0);
        chk_eq("arst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1'b1, 2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            v  = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                d[i*6 +: 6]    = {(($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0111),
                                  2'($urandom)};
                dat[i*16 +: 16] = 16'($urandom);
            end
            step(en, v, d, dat);
        end
        idle(1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
